// File: rtl/stepdown_corestate_nonoverlap_rx.sv
// Receive end of the inverted stepdown core-state line.
// Synchronises and deglitches i, then sequences non-overlapping HS/LS gate
// enables with a programmable dead time before each turn-on.
// Optional build macro: STEPDOWN_MAXON_EN adds an HS max-on-time limiter with
// a sticky fault; without it maxon_flt is tied low and HS dwell is unlimited.
module stepdown_corestate_nonoverlap_rx #(
  parameter int unsigned DGL_CYCLES   = 3,
  parameter int unsigned DT_W         = 6,
  parameter int unsigned MAXON_CYCLES = 255
) (
  input  logic            CELCLK,
  input  logic            CELRST,
  input  logic            CELV,
  input  logic            CELG,
  input  logic            SUB,
  input  logic            i,
  input  logic            en,
  input  logic [DT_W-1:0] dt_hs,
  input  logic [DT_W-1:0] dt_ls,
  output logic            hs_on,
  output logic            ls_on,
  output logic [2:0]      state,
  output logic            maxon_flt
);

  localparam int unsigned DGL_W = (DGL_CYCLES > 1) ? $clog2(DGL_CYCLES) : 1;
  localparam logic [DGL_W-1:0] DGL_LAST = DGL_W'(DGL_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    DT_HL = 3'b001,
    LS    = 3'b010,
    DT_LH = 3'b011,
    HS    = 3'b100
  } state_t;

  state_t            st;
  state_t            st_nx;
  logic [DT_W-1:0]   dt_cnt;
  logic [DT_W-1:0]   dt_nx;
  logic              s1;
  logic              s2;
  logic              req_raw;
  logic              req;
  logic [DGL_W-1:0]  dgl_cnt;
  logic              maxon_trip;
  logic              lh_block;

  // Power/ground/substrate ties carry no logic function.
  logic unused_ties;
  assign unused_ties = ^{CELV, CELG, SUB};

  assign req_raw = ~s2;
  assign state   = st;

  // Two-flop synchroniser on the asynchronous core-state line.
  always_ff @(posedge CELCLK) begin
    if (CELRST) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= i;
      s2 <= s1;
    end
  end

  // Accept a new request level only after DGL_CYCLES consecutive differing samples.
  always_ff @(posedge CELCLK) begin
    if (CELRST) begin
      req     <= 1'b0;
      dgl_cnt <= '0;
    end else if (req_raw != req) begin
      if (dgl_cnt == DGL_LAST) begin
        req     <= req_raw;
        dgl_cnt <= '0;
      end else begin
        dgl_cnt <= dgl_cnt + DGL_W'(1);
      end
    end else begin
      dgl_cnt <= '0;
    end
  end

  // State, dead-time counter and gate enables decoded from the next state.
  always_ff @(posedge CELCLK) begin
    if (CELRST) begin
      st     <= IDLE;
      dt_cnt <= '0;
      hs_on  <= 1'b0;
      ls_on  <= 1'b0;
    end else begin
      st     <= st_nx;
      dt_cnt <= dt_nx;
      hs_on  <= (st_nx == HS);
      ls_on  <= (st_nx == LS);
    end
  end

  // Next-state logic; dead time is loaded on DT entry and counted down to zero.
  always_comb begin
    st_nx = st;
    dt_nx = dt_cnt;
    case (st)
      IDLE: begin
        if (en) begin
          st_nx = DT_HL;
          dt_nx = dt_ls;
        end
      end
      DT_HL: begin
        if (dt_cnt == '0) st_nx = LS;
        else              dt_nx = dt_cnt - DT_W'(1);
      end
      LS: begin
        if (req && !lh_block) begin
          st_nx = DT_LH;
          dt_nx = dt_hs;
        end
      end
      DT_LH: begin
        // HS never conducted, so an abort returns straight to LS.
        if (!req)                 st_nx = LS;
        else if (dt_cnt == '0)    st_nx = HS;
        else                      dt_nx = dt_cnt - DT_W'(1);
      end
      HS: begin
        if (!req || maxon_trip) begin
          st_nx = DT_HL;
          dt_nx = dt_ls;
        end
      end
      default: begin
        st_nx = IDLE;
        dt_nx = '0;
      end
    endcase
    if (!en) begin
      st_nx = IDLE;
      dt_nx = '0;
    end
  end

`ifdef STEPDOWN_MAXON_EN
  localparam int unsigned ON_W = (MAXON_CYCLES > 1) ? $clog2(MAXON_CYCLES) : 1;
  localparam logic [ON_W-1:0] ON_LAST = ON_W'(MAXON_CYCLES - 1);

  logic [ON_W-1:0] on_cnt;
  logic            lh_blk;
  logic            flt;

  assign maxon_trip = (st == HS) && (on_cnt == ON_LAST);
  assign lh_block   = lh_blk;
  assign maxon_flt  = flt;

  // HS on-time limiter; after a trip, re-entry waits for req to drop once.
  always_ff @(posedge CELCLK) begin
    if (CELRST || !en) begin
      on_cnt <= '0;
      lh_blk <= 1'b0;
      flt    <= 1'b0;
    end else begin
      if (st_nx == HS) on_cnt <= (st == HS) ? on_cnt + ON_W'(1) : '0;
      else             on_cnt <= '0;
      if (maxon_trip) begin
        flt    <= 1'b1;
        lh_blk <= 1'b1;
      end else if (!req) begin
        lh_blk <= 1'b0;
      end
    end
  end
`else
  logic unused_maxon_cfg;
  assign unused_maxon_cfg = MAXON_CYCLES[0];
  assign maxon_trip       = 1'b0;
  assign lh_block         = 1'b0;
  assign maxon_flt        = 1'b0;
`endif

endmodule

// File: tb/tb_stepdown_corestate_nonoverlap_rx.sv
// Bench for stepdown_corestate_nonoverlap_rx: directed scenarios plus random
// line activity checked every cycle against a behavioural model.
module tb_stepdown_corestate_nonoverlap_rx;

  localparam int unsigned DGL   = 3;
  localparam int unsigned DTW   = 6;
  localparam int unsigned MAXON = 8;
`ifdef STEPDOWN_MAXON_EN
  localparam bit MAXON_EN = 1'b1;
`else
  localparam bit MAXON_EN = 1'b0;
`endif

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DTHL = 3'd1;
  localparam logic [2:0] S_LS   = 3'd2;
  localparam logic [2:0] S_DTLH = 3'd3;
  localparam logic [2:0] S_HS   = 3'd4;

  logic           clk   = 1'b0;
  logic           rst   = 1'b1;
  logic           en    = 1'b1;
  logic           i     = 1'b0;
  logic [DTW-1:0] dt_hs = DTW'(5);
  logic [DTW-1:0] dt_ls = DTW'(2);
  logic           hs_on;
  logic           ls_on;
  logic [2:0]     state;
  logic           maxon_flt;

  int total = 0;
  int bad   = 0;
  bit mon_on = 1'b0;

  stepdown_corestate_nonoverlap_rx #(
    .DGL_CYCLES(DGL), .DT_W(DTW), .MAXON_CYCLES(MAXON)
  ) dut (
    .CELCLK(clk), .CELRST(rst), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
    .i(i), .en(en), .dt_hs(dt_hs), .dt_ls(dt_ls),
    .hs_on(hs_on), .ls_on(ls_on), .state(state), .maxon_flt(maxon_flt)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode code, remaining dead-time cycles, HS dwell time.
  int m_s1 = 1, m_s2 = 1, m_req = 0, m_run = 0, m_raw = 0;
  int m_mode = 0, m_wait = 0, m_hs_time = 0, m_flt = 0, m_need_low = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_s1 = 1; m_s2 = 1; m_req = 0; m_run = 0;
      m_mode = 0; m_wait = 0; m_hs_time = 0; m_flt = 0; m_need_low = 0;
    end else begin
      if (!en) begin
        m_mode = 0; m_flt = 0; m_need_low = 0;
      end else begin
        if (m_req == 0) m_need_low = 0;
        case (m_mode)
          0: begin m_mode = 1; m_wait = int'(dt_ls) + 1; end
          1: begin m_wait--; if (m_wait == 0) m_mode = 2; end
          2: if (m_req == 1 && m_need_low == 0) begin m_mode = 3; m_wait = int'(dt_hs) + 1; end
          3: begin
            if (m_req == 0) m_mode = 2;
            else begin
              m_wait--;
              if (m_wait == 0) begin m_mode = 4; m_hs_time = 0; end
            end
          end
          4: begin
            m_hs_time++;
            if (MAXON_EN && m_hs_time == int'(MAXON)) begin
              m_flt = 1; m_need_low = 1; m_mode = 1; m_wait = int'(dt_ls) + 1;
            end else if (m_req == 0) begin
              m_mode = 1; m_wait = int'(dt_ls) + 1;
            end
          end
          default: m_mode = 0;
        endcase
      end
      m_raw = 1 - m_s2;
      if (m_raw != m_req) begin
        m_run++;
        if (m_run == int'(DGL)) begin m_req = m_raw; m_run = 0; end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = int'(i);
    end
  end

  // Every-cycle checks: no overlap and agreement with the model.
  always @(negedge clk) begin
    if (mon_on) begin
      total++;
      if ((hs_on & ls_on) !== 1'b0) begin
        bad++; $display("FAIL overlap: hs_on=%b ls_on=%b t=%0t", hs_on, ls_on, $time);
      end
      total++;
      if (hs_on !== (m_mode == 4)) begin
        bad++; $display("FAIL model_hs: got=%b want=%b t=%0t", hs_on, (m_mode == 4), $time);
      end
      total++;
      if (ls_on !== (m_mode == 2)) begin
        bad++; $display("FAIL model_ls: got=%b want=%b t=%0t", ls_on, (m_mode == 2), $time);
      end
      total++;
      if (state !== 3'(m_mode)) begin
        bad++; $display("FAIL model_state: got=%0d want=%0d t=%0t", state, m_mode, $time);
      end
      total++;
      if (maxon_flt !== 1'(m_flt)) begin
        bad++; $display("FAIL model_flt: got=%b want=%0d t=%0t", maxon_flt, m_flt, $time);
      end
    end
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; i = 1'b0;
    wait_edges(2);
    mon_on = 1'b1;
    total++; if (hs_on !== 1'b0) begin bad++; $display("FAIL reset_hs: got=%b want=0", hs_on); end
    total++; if (ls_on !== 1'b0) begin bad++; $display("FAIL reset_ls: got=%b want=0", ls_on); end
    total++; if (state !== S_IDLE) begin bad++; $display("FAIL reset_state: got=%0d want=0", state); end
    total++; if (maxon_flt !== 1'b0) begin bad++; $display("FAIL reset_flt: got=%b want=0", maxon_flt); end
  endtask

  task automatic test_startup();
    @(negedge clk);
    rst = 1'b0; en = 1'b1; i = 1'b1; dt_ls = DTW'(2); dt_hs = DTW'(5);
    wait_edges(1);
    total++; if (state !== S_DTHL) begin bad++; $display("FAIL start_dthl: got=%0d want=1", state); end
    wait_edges(2);
    total++; if (ls_on !== 1'b0) begin bad++; $display("FAIL start_ls_early: got=%b want=0", ls_on); end
    wait_edges(1);
    total++; if (ls_on !== 1'b1) begin bad++; $display("FAIL start_ls_on: got=%b want=1", ls_on); end
    total++; if (state !== S_LS) begin bad++; $display("FAIL start_state: got=%0d want=2", state); end
  endtask

  task automatic test_ls_to_hs();
    @(negedge clk);
    i = 1'b0;
    wait_edges(5);
    total++; if (ls_on !== 1'b1) begin bad++; $display("FAIL lat_ls_edge5: got=%b want=1", ls_on); end
    wait_edges(1);
    total++; if (ls_on !== 1'b0) begin bad++; $display("FAIL lat_ls_edge6: got=%b want=0", ls_on); end
    total++; if (state !== S_DTLH) begin bad++; $display("FAIL lat_state_edge6: got=%0d want=3", state); end
    wait_edges(5);
    total++; if (hs_on !== 1'b0) begin bad++; $display("FAIL lat_hs_edge11: got=%b want=0", hs_on); end
    wait_edges(1);
    total++; if (hs_on !== 1'b1) begin bad++; $display("FAIL lat_hs_edge12: got=%b want=1", hs_on); end
    total++; if (state !== S_HS) begin bad++; $display("FAIL lat_state_edge12: got=%0d want=4", state); end
  endtask

  task automatic test_glitch();
    bit ok = 1'b0;
    @(negedge clk);
    i = 1'b1;
    for (int k = 0; k < 60 && !ok; k++) begin
      wait_edges(1);
      if (state === S_LS && ls_on === 1'b1) ok = 1'b1;
    end
    total++; if (!ok) begin bad++; $display("FAIL glitch_settle: got=timeout want=LS"); end
    wait_edges(6);
    @(negedge clk); i = 1'b0;
    @(negedge clk);
    @(negedge clk); i = 1'b1;
    for (int k = 0; k < 12; k++) begin
      wait_edges(1);
      total++; if (ls_on !== 1'b1) begin bad++; $display("FAIL glitch_ls: got=%b want=1 cyc=%0d", ls_on, k); end
      total++; if (state !== S_LS) begin bad++; $display("FAIL glitch_state: got=%0d want=2 cyc=%0d", state, k); end
    end
  endtask

  task automatic test_abort();
    @(negedge clk);
    dt_hs = DTW'(20); i = 1'b0;
    wait_edges(6);
    total++; if (state !== S_DTLH) begin bad++; $display("FAIL abort_dtlh: got=%0d want=3", state); end
    @(negedge clk); i = 1'b1;
    for (int k = 7; k <= 30; k++) begin
      wait_edges(1);
      total++; if (hs_on !== 1'b0) begin bad++; $display("FAIL abort_hs: got=%b want=0 edge=%0d", hs_on, k); end
      if (k == 12) begin
        total++; if (state !== S_LS) begin bad++; $display("FAIL abort_state: got=%0d want=2", state); end
        total++; if (ls_on !== 1'b1) begin bad++; $display("FAIL abort_ls: got=%b want=1", ls_on); end
      end
    end
  endtask

  task automatic test_disable();
    bit ok = 1'b0;
    @(negedge clk);
    dt_hs = DTW'(5); i = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      wait_edges(1);
      if (hs_on === 1'b1) ok = 1'b1;
    end
    total++; if (!ok) begin bad++; $display("FAIL disable_reach_hs: got=timeout want=HS"); end
    @(negedge clk); en = 1'b0;
    wait_edges(1);
    total++; if (hs_on !== 1'b0) begin bad++; $display("FAIL disable_hs: got=%b want=0", hs_on); end
    total++; if (ls_on !== 1'b0) begin bad++; $display("FAIL disable_ls: got=%b want=0", ls_on); end
    total++; if (state !== S_IDLE) begin bad++; $display("FAIL disable_state: got=%0d want=0", state); end
  endtask

  task automatic test_maxon();
    bit ok = 1'b0;
    bit seen = 1'b0;
    int cnt = 1;
    @(negedge clk);
    en = 1'b1; i = 1'b0;
    for (int k = 0; k < 80 && !ok; k++) begin
      wait_edges(1);
      if (hs_on === 1'b1) ok = 1'b1;
    end
    total++; if (!ok) begin bad++; $display("FAIL maxon_reach_hs: got=timeout want=HS"); end
    for (int k = 0; k < 100; k++) begin
      wait_edges(1);
      if (hs_on === 1'b1) cnt++;
      else break;
    end
`ifdef STEPDOWN_MAXON_EN
    total++; if (cnt != int'(MAXON)) begin bad++; $display("FAIL maxon_len: got=%0d want=%0d", cnt, MAXON); end
    total++; if (state !== S_DTHL) begin bad++; $display("FAIL maxon_state: got=%0d want=1", state); end
    total++; if (maxon_flt !== 1'b1) begin bad++; $display("FAIL maxon_flt: got=%b want=1", maxon_flt); end
    for (int k = 0; k < 40; k++) begin
      wait_edges(1);
      if (hs_on === 1'b1) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL maxon_blocked: got=hs_on want=no_hs"); end
    @(negedge clk); i = 1'b1;
    wait_edges(10);
    total++; if (maxon_flt !== 1'b1) begin bad++; $display("FAIL maxon_sticky: got=%b want=1", maxon_flt); end
    @(negedge clk); i = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 80 && !ok; k++) begin
      wait_edges(1);
      if (hs_on === 1'b1) ok = 1'b1;
    end
    total++; if (!ok) begin bad++; $display("FAIL maxon_rearm: got=timeout want=HS"); end
`else
    total++; if (cnt != 101) begin bad++; $display("FAIL hs_unlimited: got=%0d want=101", cnt); end
    total++; if (maxon_flt !== 1'b0) begin bad++; $display("FAIL flt_tied: got=%b want=0", maxon_flt); end
    total++; if (seen) begin bad++; $display("FAIL hs_unlimited_seen: got=1 want=0"); end
`endif
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 250; seg++) begin
      @(negedge clk);
      i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) en = ~en;
      else if (!en && $urandom_range(0, 2) == 0) en = 1'b1;
      if ($urandom_range(0, 3) == 0)
        dt_hs = ($urandom_range(0, 9) == 0) ? '1 : DTW'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0)
        dt_ls = ($urandom_range(0, 9) == 0) ? '1 : DTW'($urandom_range(0, 7));
      rst = ($urandom_range(0, 79) == 0);
      repeat ($urandom_range(1, 12)) @(posedge clk);
    end
    @(negedge clk);
    rst = 1'b0; en = 1'b1;
    wait_edges(100);
    total++; if ((hs_on & ls_on) !== 1'b0) begin bad++; $display("FAIL random_end_overlap: got=%b want=0", hs_on & ls_on); end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_ls_to_hs();
    test_glitch();
    test_abort();
    test_disable();
    test_maxon();
    test_random();
    @(negedge clk);
    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
